mdu_unit: RTL and testbench

//  E-stage multiply/divide unit; sits beside the ALU on the same forwarded operands.

---
 rtl/mdu_unit_pkg.sv | 29 ++
 rtl/mdu_unit.sv | 129 ++++++++++++
 tb/tb_mdu_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_unit_pkg.sv
// Shared opcodes, FSM state type and decode helpers for the multiply/divide unit.
package mdu_unit_pkg;

  // 4-bit MDU opcodes carried down the pipeline alongside the ALU op.
  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mdu_state_e;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_md_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit. Results are computed when the op is accepted and
// held in HI_tmp/LO_tmp; they land in HI/LO only after the modelled latency, so
// software sees the same timing as an iterative multiplier/divider.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        Req,
  input  logic [3:0]  MDUop,
  input  logic [31:0] MD_in1,
  input  logic [31:0] MD_in2,
  output logic        busy,
  output logic [31:0] MDU_out
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_state_e        state_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q;
  logic [31:0]       hi_q, lo_q;
  logic [31:0]       hi_tmp_q, lo_tmp_q;

  logic [63:0]       prod_s, prod_u;
  logic [31:0]       divisor_safe;
  logic [31:0]       quot_s, rem_s, quot_u, rem_u;
  logic              div_zero;
  logic [31:0]       res_hi, res_lo;
  logic [CntW-1:0]   load_cnt;

  // Arithmetic datapath: full-precision results for whichever op is presented.
  always_comb begin
    prod_s       = $signed({{32{MD_in1[31]}}, MD_in1}) * $signed({{32{MD_in2[31]}}, MD_in2});
    prod_u       = {32'b0, MD_in1} * {32'b0, MD_in2};
    div_zero     = (MD_in2 == 32'd0);
    // Feed a harmless divisor on /0; the result is discarded in that case anyway.
    divisor_safe = div_zero ? 32'd1 : MD_in2;
    quot_s       = $signed(MD_in1) / $signed(divisor_safe);
    rem_s        = $signed(MD_in1) % $signed(divisor_safe);
    quot_u       = MD_in1 / divisor_safe;
    rem_u        = MD_in1 % divisor_safe;

    res_hi = hi_q;
    res_lo = lo_q;
    unique case (MDUop)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV: begin
        if (!div_zero) begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      MDU_DIVU: begin
        if (!div_zero) begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
      default: ;
    endcase

    load_cnt = is_div_op(MDUop) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
  end

  // FSM: accept ops and mt* writes in IDLE, count latency in RUN, commit on the last cycle.
  // Divide by zero still runs the full latency; HI_tmp/LO_tmp then hold the old HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!Req) begin
            if (start && is_md_op(MDUop)) begin
              hi_tmp_q <= res_hi;
              lo_tmp_q <= res_lo;
              cnt_q    <= load_cnt;
              busy_q   <= 1'b1;
              state_q  <= StRun;
            end else if (MDUop == MDU_MTHI) begin
              hi_q <= MD_in1;
            end else if (MDUop == MDU_MTLO) begin
              lo_q <= MD_in1;
            end
          end
        end
        StRun: begin
          // Req is ignored here: the op already committed past M.
          if (cnt_q == CntW'(1)) begin
            hi_q    <= hi_tmp_q;
            lo_q    <= lo_tmp_q;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;

  // Read port: pure select on the opcode, independent of busy.
  always_comb begin
    MDU_out = 32'd0;
    unique case (MDUop)
      MDU_MFHI: MDU_out = hi_q;
      MDU_MFLO: MDU_out = lo_q;
      default:  MDU_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latency, arithmetic, Req handling, mt/mf and async reset.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        Req;
  logic [3:0]  MDUop;
  logic [31:0] MD_in1;
  logic [31:0] MD_in2;
  logic        busy;
  logic [31:0] MDU_out;

  int passes = 0;
  int total  = 0;

  mdu_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .Req    (Req),
    .MDUop  (MDUop),
    .MD_in1 (MD_in1),
    .MD_in2 (MD_in2),
    .busy   (busy),
    .MDU_out(MDU_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an op for exactly one rising edge; returns at the negedge after that edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic rq);
    @(negedge clk);
    MDUop  = op;
    MD_in1 = a;
    MD_in2 = b;
    start  = st;
    Req    = rq;
    @(negedge clk);
    MDUop  = MDU_NONE;
    start  = 1'b0;
    Req    = 1'b0;
  endtask

  // Read HI/LO through the mf* port within the low clock phase.
  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    MDUop = MDU_MFHI;
    #1 h = MDU_out;
    MDUop = MDU_MFLO;
    #1 l = MDU_out;
    MDUop = MDU_NONE;
    #1;
  endtask

  // Count busy cycles from the current negedge until busy drops (bounded).
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [31:0] h, l;
    #1;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else passes++;
    read_hilo(h, l);
    total++;
    if (h !== 32'h0 || l !== 32'h0)
      $display("FAIL reset_hilo: got %h/%h want 00000000/00000000", h, l);
    else passes++;
  endtask

  task automatic test_mult;
    logic [31:0] h, l;
    int n;
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0);
    // mf* while busy returns the old (reset) values
    read_hilo(h, l);
    total++;
    if (h !== 32'h0 || l !== 32'h0)
      $display("FAIL mf_while_busy: got %h/%h want 00000000/00000000", h, l);
    else passes++;
    count_busy(n);
    total++;
    if (n !== 5) $display("FAIL mult_busy_cycles: got %0d want 5", n);
    else passes++;
    read_hilo(h, l);
    total++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB)
      $display("FAIL mult_result: got %h/%h want ffffffff/ffffffeb", h, l);
    else passes++;

    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    count_busy(n);
    total++;
    if (n !== 5) $display("FAIL multu_busy_cycles: got %0d want 5", n);
    else passes++;
    read_hilo(h, l);
    total++;
    if (h !== 32'h0000_0001 || l !== 32'hFFFF_FFFE)
      $display("FAIL multu_result: got %h/%h want 00000001/fffffffe", h, l);
    else passes++;
  endtask

  task automatic test_div;
    logic [31:0] h, l;
    int n;
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    count_busy(n);
    total++;
    if (n !== 10) $display("FAIL div_busy_cycles: got %0d want 10", n);
    else passes++;
    read_hilo(h, l);
    total++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD)
      $display("FAIL div_result: got %h/%h want ffffffff/fffffffd", h, l);
    else passes++;

    issue(MDU_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
    count_busy(n);
    read_hilo(h, l);
    total++;
    if (h !== 32'd2 || l !== 32'd14)
      $display("FAIL divu_result: got %h/%h want 00000002/0000000e", h, l);
    else passes++;

    issue(MDU_DIVU, 32'd7, 32'd0, 1'b1, 1'b0);
    count_busy(n);
    total++;
    if (n !== 10) $display("FAIL divzero_busy_cycles: got %0d want 10", n);
    else passes++;
    read_hilo(h, l);
    total++;
    if (h !== 32'd2 || l !== 32'd14)
      $display("FAIL divzero_unchanged: got %h/%h want 00000002/0000000e", h, l);
    else passes++;
  endtask

  task automatic test_req;
    logic [31:0] h, l;
    int n;
    issue(MDU_MULT, 32'd2, 32'd3, 1'b1, 1'b1);
    count_busy(n);
    total++;
    if (n !== 0) $display("FAIL req_start_busy: got %0d want 0", n);
    else passes++;
    repeat (6) @(negedge clk);
    read_hilo(h, l);
    total++;
    if (h !== 32'd2 || l !== 32'd14)
      $display("FAIL req_start_hilo: got %h/%h want 00000002/0000000e", h, l);
    else passes++;

    // Req held through RUN must not cancel the commit.
    issue(MDU_MULT, 32'd2, 32'd3, 1'b1, 1'b0);
    Req = 1'b1;
    count_busy(n);
    Req = 1'b0;
    total++;
    if (n !== 5) $display("FAIL req_run_busy: got %0d want 5", n);
    else passes++;
    read_hilo(h, l);
    total++;
    if (h !== 32'd0 || l !== 32'd6)
      $display("FAIL req_run_result: got %h/%h want 00000000/00000006", h, l);
    else passes++;
  endtask

  task automatic test_mt;
    logic [31:0] h, l;
    int n;
    issue(MDU_MTLO, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b0) $display("FAIL mtlo_busy: got %b want 0", busy);
    else passes++;
    read_hilo(h, l);
    total++;
    if (l !== 32'h0000_1234 || h !== 32'd0)
      $display("FAIL mtlo_mflo: got %h/%h want 00000000/00001234", h, l);
    else passes++;

    issue(MDU_MTHI, 32'h0000_ABCD, 32'd0, 1'b0, 1'b1);
    read_hilo(h, l);
    total++;
    if (h !== 32'd0) $display("FAIL mthi_req_ignored: got %h want 00000000", h);
    else passes++;

    // Non-mf opcode reads zero even though LO is non-zero.
    MDUop = MDU_MTLO;
    #1;
    total++;
    if (MDU_out !== 32'd0) $display("FAIL out_non_mf: got %h want 00000000", MDU_out);
    else passes++;
    MDUop = MDU_NONE;

    issue(MDU_MULT, 32'd4, 32'd5, 1'b1, 1'b0);
    issue(MDU_MTHI, 32'h0000_DEAD, 32'd0, 1'b0, 1'b0);
    issue(MDU_MULT, 32'd9, 32'd9, 1'b1, 1'b0);
    count_busy(n);
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL start_while_busy: busy=%b want 0", busy);
    else passes++;
    read_hilo(h, l);
    total++;
    if (h !== 32'd0 || l !== 32'd20)
      $display("FAIL mt_start_while_busy: got %h/%h want 00000000/00000014", h, l);
    else passes++;
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] h, l;
    issue(MDU_MTHI, 32'h55, 32'd0, 1'b0, 1'b0);
    issue(MDU_MULT, 32'd3, 32'd3, 1'b1, 1'b0);
    // now in busy cycle 1; advance to busy cycle 3
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_mid_busy: got %b want 0", busy);
    else passes++;
    read_hilo(h, l);
    total++;
    if (h !== 32'd0 || l !== 32'd0)
      $display("FAIL reset_mid_hilo: got %h/%h want 00000000/00000000", h, l);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busy);
    else passes++;
    read_hilo(h, l);
    total++;
    if (h !== 32'd0 || l !== 32'd0)
      $display("FAIL post_reset_hilo: got %h/%h want 00000000/00000000", h, l);
    else passes++;
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    Req    = 1'b0;
    MDUop  = MDU_NONE;
    MD_in1 = 32'd0;
    MD_in2 = 32'd0;
    repeat (2) @(negedge clk);
    test_reset;
    reset = 1'b1;
    @(negedge clk);
    test_mult;
    test_div;
    test_req;
    test_mt;
    test_reset_mid_run;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
